pgm_gfx_ddr_bridge: RTL and testbench

- Sits between the sprite engine's graphics-ROM read port and the MiSTer DDR3 Avalon read channel.
- Converts the engine's single-word, level-held read requests into aligned burst reads.
- Keeps a one-line burst cache so sequential 64-bit fetches within the same line return in one cycle.
- Read-only block; graphics ROM data is preloaded into DDR3 by the loader.

---
 rtl/pgm_gfx_ddr_bridge_if.sv | 26 ++
 rtl/pgm_gfx_ddr_bridge.sv | 128 ++++++++++++
 tb/tb_pgm_gfx_ddr_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_gfx_ddr_bridge_if.sv
// Sprite-engine read port and DDR3 Avalon read channel seen by the gfx bridge.
// The bridge uses the slave modport; engine/DDR3 side models use master.
interface pgm_gfx_ddr_bridge_if;
  logic        req_rd;
  logic [28:0] req_addr;
  logic        req_busy;
  logic [63:0] req_dout;
  logic        req_dout_ready;
  logic        flush;
  logic        mem_rd;
  logic [28:0] mem_addr;
  logic [7:0]  mem_burstcnt;
  logic        mem_busy;
  logic [63:0] mem_dout;
  logic        mem_dout_ready;

  modport slave (
    input  req_rd, req_addr, flush, mem_busy, mem_dout, mem_dout_ready,
    output req_busy, req_dout, req_dout_ready, mem_rd, mem_addr, mem_burstcnt
  );

  modport master (
    output req_rd, req_addr, flush, mem_busy, mem_dout, mem_dout_ready,
    input  req_busy, req_dout, req_dout_ready, mem_rd, mem_addr, mem_burstcnt
  );
endinterface

// File: rtl/pgm_gfx_ddr_bridge.sv
// Graphics-ROM read bridge: turns single-word engine reads into aligned DDR3
// bursts and serves repeat reads from a one-line burst cache.
module pgm_gfx_ddr_bridge #(
  parameter int          BURST_LEN = 4,
  parameter logic [28:0] BASE_ADDR = 29'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  pgm_gfx_ddr_bridge_if.slave    bus,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);
  localparam int LW = $clog2(BURST_LEN);
  localparam int TW = 29 - LW;

  typedef enum logic [1:0] {IDLE, ISSUE, FILL, RESP} state_t;

  state_t          state_reg, state_next;
  logic            valid_reg;
  logic [TW-1:0]   tag_reg;
  logic [TW-1:0]   fill_tag_reg;
  logic [LW-1:0]   idx_reg;
  logic [LW-1:0]   beat_reg;
  logic            flush_pending_reg;
  logic [28:0]     mem_addr_reg;
  logic [63:0]     req_dout_reg;
  logic [15:0]     hit_cnt_reg;
  logic [15:0]     miss_cnt_reg;
  logic [63:0]     line_mem [BURST_LEN];

  logic [TW-1:0]   req_tag;
  logic [LW-1:0]   req_idx;
  logic            hit;
  logic            last_beat;

  assign req_tag   = bus.req_addr[28:LW];
  assign req_idx   = bus.req_addr[LW-1:0];
  // A flush in the same cycle as a request forces the request down the miss path.
  assign hit       = valid_reg && (req_tag == tag_reg) && !bus.flush;
  assign last_beat = bus.mem_dout_ready && (beat_reg == LW'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.req_rd) state_next = hit ? RESP : ISSUE;
      ISSUE:   if (!bus.mem_busy) state_next = FILL;
      FILL:    if (last_beat) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_busy       = (state_reg != IDLE);
    bus.req_dout_ready = (state_reg == RESP);
    bus.mem_rd         = (state_reg == ISSUE);
  end

  assign bus.mem_burstcnt = 8'(BURST_LEN);
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.req_dout     = req_dout_reg;
  assign hit_cnt          = hit_cnt_reg;
  assign miss_cnt         = miss_cnt_reg;

  // Line storage has no reset; valid_reg alone decides whether it may be used.
  always_ff @(posedge clk) begin
    if (state_reg == FILL && bus.mem_dout_ready) line_mem[beat_reg] <= bus.mem_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg         <= 1'b0;
      tag_reg           <= '0;
      fill_tag_reg      <= '0;
      idx_reg           <= '0;
      beat_reg          <= '0;
      flush_pending_reg <= 1'b0;
      mem_addr_reg      <= '0;
      req_dout_reg      <= '0;
      hit_cnt_reg       <= '0;
      miss_cnt_reg      <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.flush) valid_reg <= 1'b0;
          if (bus.req_rd) begin
            if (hit) begin
              req_dout_reg <= line_mem[req_idx];
              hit_cnt_reg  <= hit_cnt_reg + 16'd1;
            end else begin
              // The line is about to be overwritten, so drop it now.
              valid_reg         <= 1'b0;
              fill_tag_reg      <= req_tag;
              idx_reg           <= req_idx;
              mem_addr_reg      <= BASE_ADDR + {req_tag, {LW{1'b0}}};
              flush_pending_reg <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (bus.flush) flush_pending_reg <= 1'b1;
          if (!bus.mem_busy) begin
            miss_cnt_reg <= miss_cnt_reg + 16'd1;
            beat_reg     <= '0;
          end
        end
        FILL: begin
          if (bus.flush) flush_pending_reg <= 1'b1;
          if (bus.mem_dout_ready) begin
            beat_reg <= beat_reg + LW'(1);
            if (beat_reg == idx_reg) req_dout_reg <= bus.mem_dout;
            if (last_beat) begin
              tag_reg           <= fill_tag_reg;
              valid_reg         <= !(flush_pending_reg || bus.flush);
              flush_pending_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pgm_gfx_ddr_bridge.sv
// Scoreboard bench for the gfx DDR bridge: a DDR3 burst model feeds the bridge,
// expected words are queued per request and compared on each response strobe.
module tb_pgm_gfx_ddr_bridge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pgm_gfx_ddr_bridge_if bif ();
  pgm_gfx_ddr_bridge_if bif2 ();
  logic [15:0] hit_cnt, miss_cnt, hit_cnt2, miss_cnt2;

  pgm_gfx_ddr_bridge #(.BURST_LEN(4), .BASE_ADDR(29'h0)) dut (
    .clk(clk), .reset(reset), .bus(bif.slave), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  pgm_gfx_ddr_bridge #(.BURST_LEN(4), .BASE_ADDR(29'h1FFFFFFC)) dut2 (
    .clk(clk), .reset(reset), .bus(bif2.slave), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2));

  int n_checks = 0;
  int n_fail = 0;
  int cmd_cnt = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [28:0] last_cmd_addr = '0;
  logic [63:0] exp_q[$];
  logic [63:0] beat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    return {a, 6'h2A, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // DDR3 model: counts accepted commands, returns the burst with random gaps.
  initial begin
    bif.mem_dout_ready = 1'b0;
    bif.mem_dout = '0;
    forever begin
      @(negedge clk);
      if (reset && bif.mem_rd && !bif.mem_busy) begin
        cmd_cnt++;
        last_cmd_addr = bif.mem_addr;
        for (int b = 0; b < 4; b++) beat_q.push_back(mem_word(bif.mem_addr + 29'(b)));
      end
      @(posedge clk);
      #1;
      if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bif.mem_dout_ready = 1'b1;
        bif.mem_dout = beat_q.pop_front();
        last_beat_cyc = cyc;
      end else begin
        bif.mem_dout_ready = 1'b0;
        bif.mem_dout = {$urandom, $urandom};
      end
    end
  end

  // Response monitor: every strobe must match the oldest expected word.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bif.req_dout_ready === 1'b1) begin
        strobe_cnt++;
        if (exp_q.size() == 0) check("unexpected_strobe", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rdata", bif.req_dout, e);
        end
      end
    end
  end

  task automatic do_req(input logic [28:0] a, input bit exp_is_hit, input bit with_flush);
    int c0;
    int lat;
    bit seen;
    c0 = cmd_cnt;
    lat = 0;
    seen = 1'b0;
    exp_q.push_back(mem_word(a));
    bif.req_addr = a;
    bif.req_rd = 1'b1;
    bif.flush = with_flush;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      bif.flush = 1'b0;
      lat++;
      if (bif.req_dout_ready) seen = 1'b1;
    end
    bif.req_rd = 1'b0;
    check("strobe_seen", 64'(seen), 64'(1));
    if (exp_is_hit) begin
      exp_hit++;
      check("hit_latency", 64'(lat), 64'(1));
    end else begin
      exp_miss++;
      check("miss_latency", 64'(cyc - last_beat_cyc), 64'(1));
      check("cmd_addr", 64'(last_cmd_addr), 64'({a[28:2], 2'b00}));
    end
    check("cmd_count", 64'(cmd_cnt - c0), exp_is_hit ? 64'(0) : 64'(1));
    check("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
    check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    $display("req addr=0x%0h hit=%0d flush=%0d latency=%0d data=0x%0h", a, exp_is_hit, with_flush, lat, bif.req_dout);
    if (!seen) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int c1;
    int s0;
    bif.req_rd = 1'b0; bif.req_addr = '0; bif.flush = 1'b0; bif.mem_busy = 1'b0;
    bif2.req_rd = 1'b0; bif2.req_addr = '0; bif2.flush = 1'b0; bif2.mem_busy = 1'b1;
    bif2.mem_dout = '0; bif2.mem_dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_busy", 64'(bif.req_busy), 64'(0));
    check("rst_mem_rd", 64'(bif.mem_rd), 64'(0));
    check("rst_mem_addr", 64'(bif.mem_addr), 64'(0));
    check("rst_req_dout", bif.req_dout, 64'(0));
    check("rst_strobe", 64'(bif.req_dout_ready), 64'(0));
    check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
    check("burstcnt", 64'(bif.mem_burstcnt), 64'(4));

    // Cold miss, then hits on the rest of the line.
    do_req(29'h10, 1'b0, 1'b0);
    do_req(29'h11, 1'b1, 1'b0);
    do_req(29'h12, 1'b1, 1'b0);
    do_req(29'h13, 1'b1, 1'b0);
    // Flush together with a request: flush wins, request misses.
    do_req(29'h11, 1'b0, 1'b1);
    do_req(29'h10, 1'b1, 1'b0);

    // DDR3 stall during ISSUE: command held stable, accepted exactly once.
    bif.mem_busy = 1'b1;
    c1 = cmd_cnt;
    n = 0;
    fork
      do_req(29'h23, 1'b0, 1'b0);
      begin
        while (!bif.mem_rd && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
          check("busy_mem_rd", 64'(bif.mem_rd), 64'(1));
          check("busy_mem_addr", 64'(bif.mem_addr), 64'(29'h20));
          @(posedge clk);
          #1;
        end
        check("busy_no_cmd", 64'(cmd_cnt - c1), 64'(0));
        bif.mem_busy = 1'b0;
      end
    join

    // Flush mid-FILL: data still delivered, line left invalid.
    c1 = cmd_cnt;
    n = 0;
    fork
      do_req(29'h30, 1'b0, 1'b0);
      begin
        while (cmd_cnt == c1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        #1 bif.flush = 1'b1;
        @(posedge clk);
        #1 bif.flush = 1'b0;
      end
    join
    do_req(29'h30, 1'b0, 1'b0);
    do_req(29'h31, 1'b1, 1'b0);

    // Base-address wrap on the second instance.
    bif2.req_addr = 29'h4;
    bif2.req_rd = 1'b1;
    n = 0;
    while (!bif2.mem_rd && n < 20) begin @(posedge clk); #1; n++; end
    check("wrap_mem_rd", 64'(bif2.mem_rd), 64'(1));
    check("wrap_mem_addr", 64'(bif2.mem_addr), 64'(0));
    bif2.req_rd = 1'b0;
    $display("req wrap addr=0x4 mem_addr=0x%0h", bif2.mem_addr);

    // Reset in the middle of a fill: late beats are dropped, no strobe.
    c1 = cmd_cnt;
    bif.req_addr = 29'h50;
    bif.req_rd = 1'b1;
    n = 0;
    while (cmd_cnt == c1 && n < 50) begin @(posedge clk); #1; n++; end
    n = 0;
    while (beat_q.size() > 2 && n < 50) begin @(posedge clk); #1; n++; end
    s0 = strobe_cnt;
    reset = 1'b0;
    bif.req_rd = 1'b0;
    #1;
    check("midrst_busy", 64'(bif.req_busy), 64'(0));
    check("midrst_mem_rd", 64'(bif.mem_rd), 64'(0));
    check("midrst_miss_cnt", 64'(miss_cnt), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    repeat (12) begin @(posedge clk); #1; end
    n = 0;
    while (beat_q.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_no_strobe", 64'(strobe_cnt - s0), 64'(0));
    check("midrst_idle", 64'(bif.req_busy), 64'(0));
    $display("req reset mid-fill addr=0x50 strobes=%0d", strobe_cnt - s0);
    do_req(29'h31, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
